seq_divider_16by8: RTL and testbench



---
 rtl/seq_divider_16by8.sv | 135 +++++++++++++
 tb/tb_seq_divider_16by8.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/seq_divider_16by8.sv
// ============================================================================
// Module   : seq_divider_16by8
// Purpose  : Sequential restoring divider, 16-bit / 8-bit -> 8-bit quotient
//            and remainder, one quotient bit per clock, valid/ready on both
//            sides. Optional macro DIV_CHECK_EN adds divide-by-zero/overflow
//            detection at the accept edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider_16by8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [7:0]  r_rem;
  logic [7:0]  r_q;
  logic [7:0]  r_div;
  logic [2:0]  r_cnt;
  logic [7:0]  r_quot_o;
  logic [7:0]  r_rem_o;

  logic [8:0]  w_t;
  logic        w_ge;
  logic [7:0]  w_rem_nxt;
  logic [7:0]  w_q_nxt;
  logic        w_chk_fail;

  // One restoring step; the 8-bit difference is exact whenever T >= D.
  assign w_t       = {r_rem, r_q[7]};
  assign w_ge      = (w_t >= {1'b0, r_div});
  assign w_rem_nxt = w_ge ? (w_t[7:0] - r_div) : w_t[7:0];
  assign w_q_nxt   = {r_q[6:0], w_ge};

`ifdef DIV_CHECK_EN
  logic r_err;
  assign w_chk_fail = (divisor == 8'd0) || (dividend[15:8] >= divisor);
  assign err        = r_err;
`else
  assign w_chk_fail = 1'b0;
  assign err        = 1'b0;
`endif

  assign quotient  = r_quot_o;
  assign remainder = r_rem_o;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = w_chk_fail ? S_DONE : S_BUSY;
      end
      S_BUSY: begin
        if (r_cnt == 3'd0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Result registers are written only on completion, so they stay put while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem    <= 8'd0;
      r_q      <= 8'd0;
      r_div    <= 8'd0;
      r_cnt    <= 3'd0;
      r_quot_o <= 8'd0;
      r_rem_o  <= 8'd0;
`ifdef DIV_CHECK_EN
      r_err    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_div <= divisor;
            r_rem <= dividend[15:8];
            r_q   <= dividend[7:0];
            r_cnt <= 3'd7;
`ifdef DIV_CHECK_EN
            r_err <= w_chk_fail;
            if (w_chk_fail) begin
              r_quot_o <= 8'hFF;
              r_rem_o  <= 8'hFF;
            end
`endif
          end
        end
        S_BUSY: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd0) begin
            r_quot_o <= w_q_nxt;
            r_rem_o  <= w_rem_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider_16by8.sv
// ============================================================================
// Module   : tb_seq_divider_16by8
// Purpose  : Directed self-checking bench for seq_divider_16by8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_divider_16by8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        err;

  int n_total = 0;
  int n_pass  = 0;

  seq_divider_16by8 u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
  endtask

  // elat counts clock edges from the accept edge to the first out_valid sample.
  task automatic run_op(input logic [15:0] dd, input logic [7:0] dv,
                        input logic [7:0] eq, input logic [7:0] er, input logic ee,
                        input int elat, input int hold);
    int lat;
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    check("in_ready_idle", {15'd0, in_ready}, 16'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("in_ready_after_accept", {15'd0, in_ready}, 16'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 16'(lat), 16'(elat));
    check("quotient", {8'd0, quotient}, {8'd0, eq});
    check("remainder", {8'd0, remainder}, {8'd0, er});
    check("err", {15'd0, err}, {15'd0, ee});
    for (int i = 0; i < hold; i++) begin
      dividend = 16'hFFFF;
      divisor  = 8'h01;
      @(posedge clk); #1;
      check("hold_out_valid", {15'd0, out_valid}, 16'd1);
      check("hold_in_ready", {15'd0, in_ready}, 16'd0);
      check("hold_result", {quotient, remainder}, {eq, er});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_hs", {15'd0, out_valid}, 16'd0);
    check("in_ready_after_hs", {15'd0, in_ready}, 16'd1);
  endtask

  initial begin
    logic seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 16'd0;
    divisor   = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_in_ready", {15'd0, in_ready}, 16'd1);
    check("rst_result", {quotient, remainder}, 16'h0000);
    check("rst_err", {15'd0, err}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(16'h3039, 8'h7B, 8'h64, 8'h2D, 1'b0, 8, 0);
    run_op(16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 8, 0);
`ifdef DIV_CHECK_EN
    run_op(16'h1234, 8'h00, 8'hFF, 8'hFF, 1'b1, 0, 0);
    run_op(16'h0100, 8'h01, 8'hFF, 8'hFF, 1'b1, 0, 0);
`else
    run_op(16'h1234, 8'h00, 8'hFF, 8'h34, 1'b0, 8, 0);
    run_op(16'h0100, 8'h01, 8'hFF, 8'h01, 1'b0, 8, 0);
`endif
    // Backpressure, then an immediately following operation.
    run_op(16'h1000, 8'h20, 8'h80, 8'h00, 1'b0, 8, 5);
    run_op(16'h0064, 8'h0A, 8'h0A, 8'h00, 1'b0, 8, 0);

    // Reset arriving at the fourth step abandons the operation.
    @(negedge clk);
    dividend = 16'h3039;
    divisor  = 8'h7B;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", {15'd0, out_valid}, 16'd0);
    check("midrst_in_ready", {15'd0, in_ready}, 16'd1);
    check("midrst_result", {quotient, remainder}, 16'h0000);
    check("midrst_err", {15'd0, err}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    check("midrst_no_result", {15'd0, seen}, 16'd0);
    run_op(16'h00FF, 8'h10, 8'h0F, 8'h0F, 1'b0, 8, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
